// File: rtl/memory_pkg.sv
// Shared constants and clear-FSM state type for the dp_memory family.
package memory_pkg;
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_e;
endpackage

// File: rtl/memory_clear_ctrl.sv
// Clear engine: sweeps zeros across every address, one word per cycle, with busy held high.
// RESET_STATE selects whether reset launches a sweep (CLEAR) or leaves the engine dormant (IDLE).
module memory_clear_ctrl
    import memory_pkg::*;
#(
    parameter int         ADDR_WIDTH  = 6,
    parameter clr_state_e RESET_STATE = CLEAR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic [ADDR_WIDTH-1:0] clr_ptr,
    output logic                  clr_we,
    output logic                  busy
);

    clr_state_e            state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic                  busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            ptr_q   <= '0;
            busy_q  <= (RESET_STATE == CLEAR);
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    // last address written this cycle; busy drops from the next one
                    if (ptr_q == '1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_ptr = ptr_q;
    assign clr_we  = busy_q;
    assign busy    = busy_q;

endmodule

// File: rtl/dp_memory.sv
// Simple dual-port RAM: one byte-lane write and one read per cycle, 1- or 2-cycle read latency.
// Optional clear engine enabled by defining DP_MEMORY_CLEAR_EN.
module dp_memory
    import memory_pkg::*;
#(
    parameter int  ADDR_WIDTH   = 6,
    parameter int  DATA_WIDTH   = 16,
    parameter int  BYTE_WIDTH   = 8,
    parameter int  READ_LATENCY = 1,
    parameter int  RDW_MODE     = 0,
    localparam int NUM_LANES    = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_LANES-1:0]  wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic                  clr_req;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic                  clr_we;

`ifdef DP_MEMORY_CLEAR_EN
    localparam clr_state_e CLR_RESET_STATE = CLEAR;
    assign clr_req = clr;
`else
    // Engine stays in IDLE forever, so busy and clr_we fold to constant 0.
    localparam clr_state_e CLR_RESET_STATE = IDLE;
    logic unused_clr;
    assign unused_clr = clr;
    assign clr_req    = 1'b0;
`endif

    memory_clear_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_STATE(CLR_RESET_STATE)
    ) u_clear_ctrl (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_req),
        .clr_ptr(clr_ptr),
        .clr_we (clr_we),
        .busy   (busy)
    );

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_fire;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_fire = wr_en && !busy;
    assign rd_fire = rd_en && !busy;

    always_comb begin
        wr_word = mem_q[wr_addr];
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (wr_be[i]) begin
                wr_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Same-address new-data mode forwards the lane-merged word ahead of the array update.
    assign rd_word = (RDW_MODE == RDW_NEW && wr_fire && wr_addr == rd_addr) ? wr_word
                                                                             : mem_q[rd_addr];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_ptr] <= '0;
        end else if (wr_fire) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    logic                  s1_valid_q;
    logic                  s2_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_fire;
            s2_valid_q <= s1_valid_q;
            if (rd_fire) begin
                s1_data_q <= rd_word;
            end
            if (s1_valid_q) begin
                s2_data_q <= s1_data_q;
            end
        end
    end

    assign rd_valid = (READ_LATENCY == 2) ? s2_valid_q : s1_valid_q;
    assign rd_data  = (READ_LATENCY == 2) ? s2_data_q  : s1_data_q;

endmodule

// File: tb/tb_dp_memory.sv
// Self-checking bench for dp_memory: two instances (latency 1/old-data, latency 2/new-data)
// share one randomized stimulus stream and are checked against a queue-based reference model.
module tb_dp_memory;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int BW    = 8;
    localparam int NL    = DW / BW;
    localparam int DEPTH = 2 ** AW;

`ifdef DP_MEMORY_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NL-1:0] wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          clr;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          rd_valid1, rd_valid2;
    logic          busy1, busy2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dp_memory #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .READ_LATENCY(1), .RDW_MODE(0)
    ) u_l1_old (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .clr(clr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1)
    );

    dp_memory #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .READ_LATENCY(2), .RDW_MODE(1)
    ) u_l2_new (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .clr(clr),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2)
    );

    typedef struct {
        int          due;
        logic [DW-1:0] d;
        bit          k;
    } res_t;

    logic [DW-1:0] mem_m   [DEPTH];
    bit            known_m [DEPTH];
    res_t          q1[$];
    res_t          q2[$];
    int            clr_left;
    int            cyc;
    bit            e1_v, e2_v, e1_k, e2_k;
    logic [DW-1:0] e1_d, e2_d;
    int            checks;
    int            errors;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] dat,
                                            input logic [NL-1:0] be);
        logic [DW-1:0] mask;
        mask = {{BW{be[1]}}, {BW{be[0]}}};
        return (old & ~mask) | (dat & mask);
    endfunction

    task automatic model_reset();
        q1.delete();
        q2.delete();
        e1_v = 1'b0; e2_v = 1'b0;
        e1_d = '0;   e2_d = '0;
        e1_k = 1'b1; e2_k = 1'b1;
        clr_left = CLR_EN ? DEPTH : 0;
    endtask

    task automatic model_edge();
        res_t          r;
        logic [DW-1:0] old, nw;
        bit            ok, nk;
        if (rst) return;
        cyc++;
        if (clr_left > 0) begin
            mem_m[DEPTH-clr_left]   = '0;
            known_m[DEPTH-clr_left] = 1'b1;
            clr_left--;
        end else begin
            if (rd_en) begin
                old = mem_m[rd_addr];
                ok  = known_m[rd_addr];
                nw  = old;
                nk  = ok;
                if (wr_en && wr_addr == rd_addr) begin
                    nw = merge(old, wr_data, wr_be);
                    nk = ok || (wr_be == '1);
                end
                q1.push_back('{due: cyc,     d: old, k: ok});
                q2.push_back('{due: cyc + 1, d: nw,  k: nk});
            end
            if (wr_en) begin
                mem_m[wr_addr]   = merge(mem_m[wr_addr], wr_data, wr_be);
                known_m[wr_addr] = known_m[wr_addr] || (wr_be == '1);
            end
            if (clr && CLR_EN) clr_left = DEPTH;
        end
        e1_v = 1'b0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            r = q1.pop_front(); e1_v = 1'b1; e1_d = r.d; e1_k = r.k;
        end
        e2_v = 1'b0;
        if (q2.size() > 0 && q2[0].due == cyc) begin
            r = q2.pop_front(); e2_v = 1'b1; e2_d = r.d; e2_k = r.k;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic test_reset();
        int busy_cnt;
        idle_inputs();
        wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if (rd_valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %b exp 0", rd_valid1); end
        checks++; if (rd_valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid2 got %b exp 0", rd_valid2); end
        checks++; if (rd_data1 !== 16'h0000) begin errors++; $display("FAIL reset_data1 got %h exp 0000", rd_data1); end
        checks++; if (rd_data2 !== 16'h0000) begin errors++; $display("FAIL reset_data2 got %h exp 0000", rd_data2); end
        repeat (2) tick();
        rst = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy1) busy_cnt++;
            checks++;
            if (busy1 !== (clr_left > 0) || busy2 !== (clr_left > 0)) begin
                errors++; $display("FAIL reset_busy cyc %0d got %b/%b exp %b", i, busy1, busy2, clr_left > 0);
            end
            tick();
        end
        checks++;
        if (busy_cnt != (CLR_EN ? DEPTH : 0)) begin
            errors++; $display("FAIL reset_busy_len got %0d exp %0d", busy_cnt, CLR_EN ? DEPTH : 0);
        end
    endtask

    task automatic test_clear_reads();
`ifndef DP_MEMORY_CLEAR_EN
        for (int a = 0; a < DEPTH; a++) begin
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'($urandom); wr_be = '1;
            tick();
        end
        idle_inputs();
`endif
        for (int a = 0; a < DEPTH + 3; a++) begin
            rd_en = (a < DEPTH); rd_addr = AW'(a);
            tick();
            checks++; if (rd_valid1 !== e1_v || rd_valid2 !== e2_v) begin
                errors++; $display("FAIL clear_reads_valid a %0d got %b/%b exp %b/%b", a, rd_valid1, rd_valid2, e1_v, e2_v);
            end
            if (e1_k) begin checks++; if (rd_data1 !== e1_d) begin
                errors++; $display("FAIL clear_reads_data1 a %0d got %h exp %h", a, rd_data1, e1_d); end end
            if (e2_k) begin checks++; if (rd_data2 !== e2_d) begin
                errors++; $display("FAIL clear_reads_data2 a %0d got %h exp %h", a, rd_data2, e2_d); end end
        end
        idle_inputs();
    endtask

    task automatic test_byte_lanes();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF; wr_be = 2'b11;
        tick();
        wr_data = {8'h12, 8'($urandom)}; wr_be = 2'b10;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_valid1 !== 1'b1) begin errors++; $display("FAIL lanes_valid1_p1 got %b exp 1", rd_valid1); end
        checks++; if (rd_data1 !== 16'h12EF) begin errors++; $display("FAIL lanes_data1 got %h exp 12EF", rd_data1); end
        checks++; if (rd_valid2 !== 1'b0) begin errors++; $display("FAIL lanes_valid2_p1 got %b exp 0", rd_valid2); end
        tick();
        checks++; if (rd_valid1 !== 1'b0) begin errors++; $display("FAIL lanes_valid1_p2 got %b exp 0", rd_valid1); end
        checks++; if (rd_data1 !== 16'h12EF) begin errors++; $display("FAIL lanes_hold1 got %h exp 12EF", rd_data1); end
        checks++; if (rd_valid2 !== 1'b1) begin errors++; $display("FAIL lanes_valid2_p2 got %b exp 1", rd_valid2); end
        checks++; if (rd_data2 !== 16'h12EF) begin errors++; $display("FAIL lanes_data2 got %h exp 12EF", rd_data2); end
        tick();
    endtask

    task automatic test_rdw();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1111; wr_be = 2'b11;
        tick();
        wr_data = 16'h2222; rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        idle_inputs();
        checks++; if (rd_valid1 !== 1'b1 || rd_data1 !== 16'h1111) begin
            errors++; $display("FAIL rdw_old got %b/%h exp 1/1111", rd_valid1, rd_data1); end
        tick();
        checks++; if (rd_valid2 !== 1'b1 || rd_data2 !== 16'h2222) begin
            errors++; $display("FAIL rdw_new got %b/%h exp 1/2222", rd_valid2, rd_data2); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_data1 !== 16'h2222) begin errors++; $display("FAIL rdw_after1 got %h exp 2222", rd_data1); end
        tick();
        checks++; if (rd_data2 !== 16'h2222) begin errors++; $display("FAIL rdw_after2 got %h exp 2222", rd_data2); end
    endtask

    task automatic test_busy_ignore();
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hA5A5; wr_be = 2'b11;
        tick();
        clr = 1'b1; wr_data = 16'h5A5A; rd_en = 1'b1; rd_addr = 4'd2;
        for (int i = 0; i < DEPTH + 2; i++) begin
            tick();
            clr = 1'b0;
            wr_addr = AW'($urandom_range(0, 3)); wr_data = DW'($urandom) | 16'h0101; wr_be = '1;
            rd_addr = AW'($urandom);
            checks++; if (busy1 !== (clr_left > 0) || busy2 !== (clr_left > 0)) begin
                errors++; $display("FAIL busy_flag i %0d got %b/%b exp %b", i, busy1, busy2, clr_left > 0); end
            checks++; if (rd_valid1 !== e1_v || rd_valid2 !== e2_v) begin
                errors++; $display("FAIL busy_valid i %0d got %b/%b exp %b/%b", i, rd_valid1, rd_valid2, e1_v, e2_v); end
            checks++; if (rd_data1 !== e1_d || rd_data2 !== e2_d) begin
                errors++; $display("FAIL busy_data i %0d got %h/%h exp %h/%h", i, rd_data1, rd_data2, e1_d, e2_d); end
            if (i == DEPTH - 1) idle_inputs();
        end
        idle_inputs();
        for (int a = 0; a < DEPTH + 2; a++) begin
            rd_en = (a < DEPTH); rd_addr = AW'(a);
            tick();
            checks++; if (rd_valid1 !== e1_v || rd_data1 !== e1_d) begin
                errors++; $display("FAIL busy_after1 a %0d got %b/%h exp %b/%h", a, rd_valid1, rd_data1, e1_v, e1_d); end
            checks++; if (rd_valid2 !== e2_v || rd_data2 !== e2_d) begin
                errors++; $display("FAIL busy_after2 a %0d got %b/%h exp %b/%h", a, rd_valid2, rd_data2, e2_v, e2_d); end
        end
        idle_inputs();
    endtask

    task automatic test_rst_mid_sweep();
        int busy_cnt;
        int guard;
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hC3C3; wr_be = 2'b11;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd7;
        tick();
        rd_en = 1'b0;
        repeat (2) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        guard = 0;
        while (clr_left != 7 && guard < 20) begin
            tick();
            guard++;
        end
        checks++; if (guard >= 20) begin errors++; $display("FAIL rstmid_reach got %0d exp 7", clr_left); end
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin
            errors++; $display("FAIL rstmid_valid got %b/%b exp 0/0", rd_valid1, rd_valid2); end
        checks++; if (rd_data1 !== 16'h0000 || rd_data2 !== 16'h0000) begin
            errors++; $display("FAIL rstmid_data got %h/%h exp 0000/0000", rd_data1, rd_data2); end
        tick();
        rst = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            if (busy2) busy_cnt++;
            tick();
        end
        checks++; if (busy_cnt != DEPTH) begin errors++; $display("FAIL rstmid_busy_len got %0d exp %0d", busy_cnt, DEPTH); end
        for (int a = 0; a < DEPTH + 2; a++) begin
            rd_en = (a < DEPTH); rd_addr = AW'(a);
            tick();
            checks++; if (rd_valid1 !== e1_v || rd_data1 !== e1_d) begin
                errors++; $display("FAIL rstmid_read1 a %0d got %b/%h exp %b/%h", a, rd_valid1, rd_data1, e1_v, e1_d); end
            checks++; if (rd_valid2 !== e2_v || rd_data2 !== e2_d) begin
                errors++; $display("FAIL rstmid_read2 a %0d got %b/%h exp %b/%h", a, rd_valid2, rd_data2, e2_v, e2_d); end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        int pulses, first, last;
        for (int a = 0; a < DEPTH; a++) begin
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'($urandom); wr_be = '1;
            tick();
        end
        wr_en = 1'b0;
        pulses = 0; first = -1; last = -1;
        for (int k = 0; k < DEPTH + 3; k++) begin
            rd_en = (k < DEPTH); rd_addr = AW'(k);
            tick();
            if (rd_valid2) begin
                if (first < 0) first = k;
                last = k;
                pulses++;
            end
            checks++; if (rd_valid2 !== e2_v || rd_data2 !== e2_d) begin
                errors++; $display("FAIL b2b_read2 k %0d got %b/%h exp %b/%h", k, rd_valid2, rd_data2, e2_v, e2_d); end
            checks++; if (rd_valid1 !== e1_v || rd_data1 !== e1_d) begin
                errors++; $display("FAIL b2b_read1 k %0d got %b/%h exp %b/%h", k, rd_valid1, rd_data1, e1_v, e1_d); end
        end
        checks++; if (pulses != DEPTH || last - first != DEPTH - 1) begin
            errors++; $display("FAIL b2b_pulses got %0d span %0d exp %0d span %0d", pulses, last - first, DEPTH, DEPTH - 1); end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wr_en   = $urandom_range(0, 3) != 0;
            wr_addr = AW'($urandom);
            wr_data = DW'($urandom);
            wr_be   = NL'($urandom);
            rd_en   = $urandom_range(0, 3) != 0;
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            clr     = $urandom_range(0, 63) == 0;
            tick();
            checks++; if (busy1 !== (clr_left > 0) || busy2 !== (clr_left > 0)) begin
                errors++; $display("FAIL rand_busy i %0d got %b/%b exp %b", i, busy1, busy2, clr_left > 0); end
            checks++; if (rd_valid1 !== e1_v || rd_valid2 !== e2_v) begin
                errors++; $display("FAIL rand_valid i %0d got %b/%b exp %b/%b", i, rd_valid1, rd_valid2, e1_v, e2_v); end
            if (e1_k) begin checks++; if (rd_data1 !== e1_d) begin
                errors++; $display("FAIL rand_data1 i %0d got %h exp %h", i, rd_data1, e1_d); end end
            if (e2_k) begin checks++; if (rd_data2 !== e2_d) begin
                errors++; $display("FAIL rand_data2 i %0d got %h exp %h", i, rd_data2, e2_d); end end
        end
        idle_inputs();
        repeat (DEPTH + 3) tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        for (int a = 0; a < DEPTH; a++) begin
            mem_m[a]   = '0;
            known_m[a] = 1'b0;
        end
        test_reset();
        test_clear_reads();
        test_byte_lanes();
        test_rdw();
`ifdef DP_MEMORY_CLEAR_EN
        test_busy_ignore();
        test_rst_mid_sweep();
`endif
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_memory.md
DP_MEMORY -- requirements
Module: dp_memory

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6: address bits; depth = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: word width in bits.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8: lane width; DATA_WIDTH is a multiple of BYTE_WIDTH; NUM_LANES = DATA_WIDTH/BYTE_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1: read latency in cycles, legal values 1 or 2.
REQ-005 SHALL have parameter RDW_MODE, default 0: same-address read-during-write result; 0 = old data, 1 = new data.
REQ-006 SHALL have these ports, as name, direction, width, meaning:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: write request.
- wr_addr, input, ADDR_WIDTH: write address.
- wr_data, input, DATA_WIDTH: write data.
- wr_be, input, NUM_LANES: lane enables; bit i covers lane i.
- rd_en, input, 1: read request.
- rd_addr, input, ADDR_WIDTH: read address.
- clr, input, 1: request a full-array clear.
- rd_data, output, DATA_WIDTH: read data.
- rd_valid, output, 1: rd_data carries a new read result this cycle.
- busy, output, 1: clear in progress; requests are ignored.

Function
REQ-007 SHALL write lane i of mem[wr_addr] from wr_data lane i on the rising edge when wr_en=1, busy=0 and wr_be[i]=1; other lanes are unchanged.
REQ-008 SHALL accept a read when rd_en=1 and busy=0, and present the result READ_LATENCY cycles later with rd_valid=1 for exactly one cycle.
REQ-009 SHALL hold rd_data at its last value when no result is presented.
REQ-010 SHALL handle a read and write to the same address in the same cycle per RDW_MODE:
- 0: return pre-write contents.
- 1: return the lane-merged post-write word.
REQ-011 SHALL treat a read and write to different addresses in the same cycle as fully independent.
REQ-012 SHALL sustain one read and one write per cycle with no bubbles; pipeline entries are independent.
REQ-013 SHALL implement an FSM with two states:
- CLEAR: busy=1; writes 0 to address clr_ptr, then increments clr_ptr; after address 2**ADDR_WIDTH-1 is written, goes to IDLE; busy is 0 from the following cycle.
- IDLE: busy=0; clr=1 sets clr_ptr to 0 and goes to CLEAR next cycle.
REQ-014 SHALL ignore wr_en, rd_en and clr while busy=1; reads already in the pipeline still complete.
REQ-015 SHALL take exactly 2**ADDR_WIDTH cycles per clear sweep.
REQ-016 SHALL give a clr asserted in the same cycle as wr_en/rd_en in IDLE lower priority than the request: the request completes, and the sweep starts next cycle.

Reset
REQ-017 SHALL on rst=1 immediately drive rd_data=0, rd_valid=0, flush the read pipeline and set clr_ptr=0.
REQ-018 SHALL on rst enter CLEAR when DP_MEMORY_CLEAR_EN is defined, otherwise IDLE.
REQ-019 SHALL NOT reset the array except through the sweep; rst during a sweep restarts it at address 0.

Configuration
REQ-020 SHALL include the clear engine (FSM, clr_ptr, sweep, clr honoured, busy driven) when DP_MEMORY_CLEAR_EN is defined.
REQ-021 SHALL, without DP_MEMORY_CLEAR_EN, ignore clr, tie busy to 0 and leave array contents undefined after reset.

Structure
REQ-022 SHALL place in the shared package memory_pkg: RDW_OLD=0, RDW_NEW=1, and the clear-FSM state type (CLEAR, IDLE).
REQ-023 SHALL isolate the clear engine in one sub-module, memory_clear_ctrl (outputs: clr_ptr, clr_we, busy).

Verification
REQ-024 SHALL cover each scenario below, using ADDR_WIDTH=4, DATA_WIDTH=16, BYTE_WIDTH=8 unless stated:
- Reset then idle (clear enabled): busy=1 for exactly 16 cycles; then reads of addresses 0..15 all return 0x0000.
- Write 0xBEEF to address 3 with be=11, then 0x12xx with be=10: read of address 3 returns 0x12EF with rd_valid at cycle +1 (READ_LATENCY=1) and at cycle +2 (READ_LATENCY=2).
- Address 5 holds 0x1111; same-cycle write 0x2222/read at address 5: returns 0x1111 with RDW_MODE=0, 0x2222 with RDW_MODE=1.
- Requests while busy: wr_en/rd_en asserted during a sweep; no write occurs and no rd_valid is produced.
- rst pulsed at sweep address 9: rd_valid=0 immediately; sweep restarts at 0 and busy lasts 16 more cycles.
- Back-to-back reads of addresses 0..15 (READ_LATENCY=2): 16 consecutive rd_valid pulses, data in order.
